// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Shared definitions for the Y86-64 writeback stage:
//   - data width and register count
//   - processor status codes (stat_t)
//   - instruction codes and the "no register" ID
//   - next_stat(): status priority encoder used by the writeback stage
// ---------------------------------------------------------------------------
package y86_pkg;

   localparam int XLEN = 64;
   localparam int NREG = 15;

   localparam logic [3:0] RNONE = 4'hF;

   typedef enum logic [2:0] {
      STAT_AOK = 3'd1,
      STAT_HLT = 3'd2,
      STAT_ADR = 3'd3,
      STAT_INS = 3'd4
   } stat_t;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   // Address faults outrank an illegal instruction, which outranks halt.
   function automatic stat_t next_stat(input logic       imem_error,
                                       input logic       dmem_error,
                                       input logic       instr_valid,
                                       input logic [3:0] icode);
      if (imem_error || dmem_error) return STAT_ADR;
      if (!instr_valid)             return STAT_INS;
      if (icode == IHALT)           return STAT_HLT;
      return STAT_AOK;
   endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// ---------------------------------------------------------------------------
// writeback_stage_if
// Bundles the memory-stage completion bus, the decode read ports and the
// architectural status outputs of the writeback stage.
//   master : pipeline side (drives completion info and read addresses)
//   slave  : writeback stage (returns read data, stat, halted, retired)
// ---------------------------------------------------------------------------
interface writeback_stage_if
   import y86_pkg::*;
#(
   parameter int XLEN = y86_pkg::XLEN
);
   logic            valid;
   logic [3:0]      icode;
   logic            instr_valid;
   logic            imem_error;
   logic            dmem_error;
   logic [3:0]      dstE;
   logic [3:0]      dstM;
   logic [XLEN-1:0] valE;
   logic [XLEN-1:0] valM;
   logic [3:0]      srcA;
   logic [3:0]      srcB;
   logic [XLEN-1:0] valA;
   logic [XLEN-1:0] valB;
   stat_t           stat;
   logic            halted;
   logic [63:0]     retired;

   modport master (
      output valid, icode, instr_valid, imem_error, dmem_error,
             dstE, dstM, valE, valM, srcA, srcB,
      input  valA, valB, stat, halted, retired
   );

   modport slave (
      input  valid, icode, instr_valid, imem_error, dmem_error,
             dstE, dstM, valE, valM, srcA, srcB,
      output valA, valB, stat, halted, retired
   );

endinterface

// File: rtl/y86_regfile.sv
// ---------------------------------------------------------------------------
// y86_regfile
// NREG x XLEN architectural register file.
//   clk, rst         : clock, asynchronous active-high reset (clears all regs)
//   we_e/id_e/d_e    : write port E (ALU result)
//   we_m/id_m/d_m    : write port M (memory result), wins over E on same ID
//   src_a/src_b      : asynchronous read addresses; RNONE reads as zero
//   val_a/val_b      : read data of current register state (no bypass)
// ---------------------------------------------------------------------------
module y86_regfile
   import y86_pkg::*;
#(
   parameter int XLEN = y86_pkg::XLEN,
   parameter int NREG = y86_pkg::NREG
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            we_e,
   input  logic [3:0]      id_e,
   input  logic [XLEN-1:0] d_e,
   input  logic            we_m,
   input  logic [3:0]      id_m,
   input  logic [XLEN-1:0] d_m,
   input  logic [3:0]      src_a,
   input  logic [3:0]      src_b,
   output logic [XLEN-1:0] val_a,
   output logic [XLEN-1:0] val_b
);

   logic [XLEN-1:0] regs [NREG];

   // NOTE: the array is reset element by element because the architecture
   // requires every register to read zero right after reset; this keeps it
   // in flops rather than a RAM macro, which is fine at 15 entries.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments here so the two ports update
         // together at the edge; the M write is placed last so it overrides E
         // when both target the same register (popq %rsp).
         if (we_e && id_e != RNONE) regs[id_e] <= d_e;
         if (we_m && id_m != RNONE) regs[id_m] <= d_m;
      end
   end

   assign val_a = (src_a == RNONE) ? '0 : regs[src_a];
   assign val_b = (src_b == RNONE) ? '0 : regs[src_b];

endmodule

// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
// Commits completing instructions: updates the register file, the registered
// processor status, the sticky halt flag and the retired-instruction counter.
//   clk, rst : clock, asynchronous active-high reset
//   wb       : writeback_stage_if.slave (completion bus, read ports, status)
// Once halted, every input is ignored until reset.
// ---------------------------------------------------------------------------
module writeback_stage
   import y86_pkg::*;
#(
   parameter int XLEN = y86_pkg::XLEN,
   parameter int NREG = y86_pkg::NREG
)(
   input  logic       clk,
   input  logic       rst,
   writeback_stage_if.slave wb
);

   stat_t       stat_q;
   logic        halted_q;
   logic [63:0] retired_q;
   stat_t       nstat;
   logic        commit;
   logic        we_e;
   logic        we_m;

   assign nstat  = next_stat(wb.imem_error, wb.dmem_error, wb.instr_valid, wb.icode);
   assign commit = wb.valid && !halted_q;

   // Registers are written only by instructions that complete normally;
   // faulting or halting instructions leave architectural state untouched.
   always_comb begin
      // NOTE: defaults first so no path leaves an enable unassigned (no latch).
      we_e = 1'b0;
      we_m = 1'b0;
      if (commit && nstat == STAT_AOK) begin
         we_e = 1'b1;
         we_m = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_q    <= STAT_AOK;
         halted_q  <= 1'b0;
         retired_q <= '0;
      end else if (commit) begin
         stat_q <= nstat;
         if (nstat != STAT_AOK) halted_q <= 1'b1;
         // HLT retires the halt instruction itself; faults do not retire.
         if (nstat == STAT_AOK || nstat == STAT_HLT) retired_q <= retired_q + 64'd1;
      end
   end

   y86_regfile #(
      .XLEN (XLEN),
      .NREG (NREG)
   ) u_regfile (
      .clk   (clk),
      .rst   (rst),
      .we_e  (we_e),
      .id_e  (wb.dstE),
      .d_e   (wb.valE),
      .we_m  (we_m),
      .id_m  (wb.dstM),
      .d_m   (wb.valM),
      .src_a (wb.srcA),
      .src_b (wb.srcB),
      .val_a (wb.valA),
      .val_b (wb.valB)
   );

   assign wb.stat    = stat_q;
   assign wb.halted  = halted_q;
   assign wb.retired = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// ---------------------------------------------------------------------------
// tb_writeback_stage
// Directed stimulus for writeback_stage. Each stimulus step drives the bus on
// the falling edge and pushes the architectural state expected after the next
// rising edge into a scoreboard queue; an independent monitor pops and
// compares shortly after each rising edge.
// ---------------------------------------------------------------------------
module tb_writeback_stage;
   import y86_pkg::*;

   typedef struct {
      string       name;
      logic [63:0] val_a;
      logic [63:0] val_b;
      logic [2:0]  stat;
      logic        halted;
      logic [63:0] retired;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb [$];

   always #5 clk = ~clk;

   writeback_stage_if #(.XLEN(64)) wb ();

   writeback_stage dut (
      .clk (clk),
      .rst (rst),
      .wb  (wb.slave)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic push(input string name, input logic [63:0] ea, input logic [63:0] eb,
                       input logic [2:0] st, input logic h, input logic [63:0] ret);
      exp_t e;
      e.name = name; e.val_a = ea; e.val_b = eb;
      e.stat = st; e.halted = h; e.retired = ret;
      sb.push_back(e);
   endtask

   // One completing instruction (or idle cycle when v=0) plus read addresses.
   task automatic drive(input logic v, input logic [3:0] ic, input logic iv,
                        input logic ime, input logic dme,
                        input logic [3:0] de, input logic [3:0] dm,
                        input logic [63:0] ve, input logic [63:0] vm,
                        input logic [3:0] sa, input logic [3:0] sb_id);
      @(negedge clk);
      wb.valid = v; wb.icode = ic; wb.instr_valid = iv;
      wb.imem_error = ime; wb.dmem_error = dme;
      wb.dstE = de; wb.dstM = dm; wb.valE = ve; wb.valM = vm;
      wb.srcA = sa; wb.srcB = sb_id;
   endtask

   // Short reset pulse entirely between clock edges: only an asynchronous
   // reset can take effect.
   task automatic rst_pulse(input string name, input logic [3:0] sa, input logic [3:0] sb_id);
      drive(1'b0, INOP, 1'b1, 1'b0, 1'b0, RNONE, RNONE, '0, '0, sa, sb_id);
      push(name, 64'h0, 64'h0, 3'd1, 1'b0, 64'd0);
      #1 rst = 1'b1;
      #2 rst = 1'b0;
   endtask

   // Monitor: compare against the oldest expectation after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.name, ".valA"},    wb.valA,            e.val_a);
            check({e.name, ".valB"},    wb.valB,            e.val_b);
            check({e.name, ".stat"},    {61'd0, wb.stat},   {61'd0, e.stat});
            check({e.name, ".halted"},  {63'd0, wb.halted}, {63'd0, e.halted});
            check({e.name, ".retired"}, wb.retired,         e.retired);
         end
      end
   end

   initial begin
      wb.valid = 1'b0; wb.icode = INOP; wb.instr_valid = 1'b1;
      wb.imem_error = 1'b0; wb.dmem_error = 1'b0;
      wb.dstE = RNONE; wb.dstM = RNONE; wb.valE = '0; wb.valM = '0;
      wb.srcA = RNONE; wb.srcB = RNONE;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset state, RNONE reads zero
      drive(1'b0, INOP, 1'b1, 1'b0, 1'b0, RNONE, RNONE, '0, '0, RNONE, RNONE);
      push("reset", 64'h0, 64'h0, 3'd1, 1'b0, 64'd0);

      // irmovq -> R2
      drive(1'b1, IIRMOVQ, 1'b1, 1'b0, 1'b0, 4'd2, RNONE, 64'h1234567890ABCDEF, '0, 4'd2, RNONE);
      push("irmovq", 64'h1234567890ABCDEF, 64'h0, 3'd1, 1'b0, 64'd1);

      // rrmovq -> R6, read R6 and R2
      drive(1'b1, IRRMOVQ, 1'b1, 1'b0, 1'b0, 4'd6, RNONE, 64'hDEADBEEF00000001, '0, 4'd6, 4'd2);
      push("rrmovq", 64'hDEADBEEF00000001, 64'h1234567890ABCDEF, 3'd1, 1'b0, 64'd2);

      // mrmovq -> R7 via port M, both read ports on the same register
      drive(1'b1, IMRMOVQ, 1'b1, 1'b0, 1'b0, RNONE, 4'd7, 64'h5, 64'h0F0F0F0F0F0F0F0F, 4'd7, 4'd7);
      push("mrmovq_same_src", 64'h0F0F0F0F0F0F0F0F, 64'h0F0F0F0F0F0F0F0F, 3'd1, 1'b0, 64'd3);

      // popq %rsp: both ports on R4, valM wins
      drive(1'b1, IPOPQ, 1'b1, 1'b0, 1'b0, 4'd4, 4'd4, 64'h100, 64'hA5A5A5A5A5A5A5A5, 4'd4, 4'd6);
      push("popq_rsp", 64'hA5A5A5A5A5A5A5A5, 64'hDEADBEEF00000001, 3'd1, 1'b0, 64'd4);

      // popq %r8: both write ports to different registers
      drive(1'b1, IPOPQ, 1'b1, 1'b0, 1'b0, 4'd4, 4'd8, 64'h108, 64'h77, 4'd4, 4'd8);
      push("popq_r8", 64'h108, 64'h77, 3'd1, 1'b0, 64'd5);

      // Idle cycles with churning dst/val inputs: nothing changes
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, IIRMOVQ, 1'b1, 1'b0, 1'b0, 4'(i), 4'(13 - i),
               64'hCAFE0000 + 64'(i), 64'hBEEF0000 + 64'(i), 4'd2, 4'd4);
         push("idle", 64'h1234567890ABCDEF, 64'h108, 3'd1, 1'b0, 64'd5);
      end

      // Illegal instruction: INS, R5 untouched, no retire
      drive(1'b1, IOPQ, 1'b0, 1'b0, 1'b0, 4'd5, RNONE, 64'h55, '0, 4'd5, 4'd2);
      push("illegal", 64'h0, 64'h1234567890ABCDEF, 3'd4, 1'b1, 64'd5);

      // Halted: a legal write is ignored
      drive(1'b1, IIRMOVQ, 1'b1, 1'b0, 1'b0, 4'd5, RNONE, 64'h66, '0, 4'd5, 4'd8);
      push("halted_ignore", 64'h0, 64'h77, 3'd4, 1'b1, 64'd5);

      // Asynchronous reset pulse clears everything
      rst_pulse("async_rst1", 4'd2, 4'd4);

      // imem_error together with instr_valid=0 -> ADR
      drive(1'b1, IIRMOVQ, 1'b0, 1'b1, 1'b0, 4'd2, RNONE, 64'h22, '0, 4'd2, RNONE);
      push("adr_priority", 64'h0, 64'h0, 3'd3, 1'b1, 64'd0);

      rst_pulse("async_rst2", 4'd2, RNONE);

      // One good instruction, then mrmovq with dmem_error
      drive(1'b1, IIRMOVQ, 1'b1, 1'b0, 1'b0, 4'd1, RNONE, 64'h11, '0, 4'd1, RNONE);
      push("irmovq_r1", 64'h11, 64'h0, 3'd1, 1'b0, 64'd1);
      drive(1'b1, IMRMOVQ, 1'b1, 1'b0, 1'b1, RNONE, 4'd3, '0, 64'hFFFFFFFFFFFFFFFF, 4'd3, 4'd1);
      push("dmem_error", 64'h0, 64'h11, 3'd3, 1'b1, 64'd1);
      drive(1'b1, IIRMOVQ, 1'b1, 1'b0, 1'b0, 4'd3, RNONE, 64'h33, '0, 4'd3, 4'd1);
      push("post_adr_ignore", 64'h0, 64'h11, 3'd3, 1'b1, 64'd1);

      rst_pulse("async_rst3", 4'd1, 4'd3);

      // halt retires and stops
      drive(1'b1, IHALT, 1'b1, 1'b0, 1'b0, RNONE, RNONE, '0, '0, 4'd1, RNONE);
      push("halt", 64'h0, 64'h0, 3'd2, 1'b1, 64'd1);
      drive(1'b1, IIRMOVQ, 1'b1, 1'b0, 1'b0, 4'd1, RNONE, 64'h44, '0, 4'd1, RNONE);
      push("post_hlt_ignore", 64'h0, 64'h0, 3'd2, 1'b1, 64'd1);

      rst_pulse("async_rst4", 4'd1, RNONE);

      // Write, then reset held across an edge carrying another write
      drive(1'b1, IIRMOVQ, 1'b1, 1'b0, 1'b0, 4'd2, RNONE, 64'hAB, '0, 4'd2, 4'd3);
      push("pre_edge_rst", 64'hAB, 64'h0, 3'd1, 1'b0, 64'd1);
      drive(1'b1, IIRMOVQ, 1'b1, 1'b0, 1'b0, 4'd3, RNONE, 64'hCD, '0, 4'd2, 4'd3);
      rst = 1'b1;
      push("edge_rst", 64'h0, 64'h0, 3'd1, 1'b0, 64'd0);
      drive(1'b0, INOP, 1'b1, 1'b0, 1'b0, RNONE, RNONE, '0, '0, 4'd2, 4'd3);
      rst = 1'b0;
      push("after_edge_rst", 64'h0, 64'h0, 3'd1, 1'b0, 64'd0);

      // nop retires without writing; R14 boundary register write
      drive(1'b1, INOP, 1'b1, 1'b0, 1'b0, RNONE, RNONE, 64'h1, 64'h2, 4'd14, 4'd2);
      push("nop", 64'h0, 64'h0, 3'd1, 1'b0, 64'd1);
      drive(1'b1, IIRMOVQ, 1'b1, 1'b0, 1'b0, 4'd14, RNONE, 64'hE, '0, 4'd14, 4'd0);
      push("r14", 64'hE, 64'h0, 3'd1, 1'b0, 64'd2);

      drive(1'b0, INOP, 1'b1, 1'b0, 1'b0, RNONE, RNONE, '0, '0, RNONE, RNONE);
      for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
      #3;
      check("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
